// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_ctrl : single-outstanding memory access controller (IDLE/ISSUE/RESP)
// Optional: define MEM_BOUNDS_CHECK_EN to reject addresses outside ADDR_LO..ADDR_HI
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int WIDTH   = 64,
  parameter int ADDR_LO = 1,
  parameter int ADDR_HI = 20
) (
  input  logic             clk,
  input  logic             res,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] data,
  output logic             read,
  output logic             write,
  input  logic [WIDTH-1:0] valM,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_valM,
  output logic             rsp_err,
  output logic [15:0]      acc_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rsp_valm_q, rsp_valm_d;
  logic             rsp_err_q, rsp_err_d;
  logic [15:0]      acc_cnt_q, acc_cnt_d;

  logic in_issue;
  logic op_legal;
  logic in_range;
  logic acc_err;
  logic do_read;
  logic do_write;

  // Error is judged from the latched request so it is stable for the whole ISSUE cycle.
  assign in_issue = (state_q == ISSUE);
  assign op_legal = (op_q == OP_READ) || (op_q == OP_WRITE);
  assign in_range = (addr_q >= WIDTH'(ADDR_LO)) && (addr_q <= WIDTH'(ADDR_HI));
  assign acc_err  = !op_legal || (BOUNDS_EN && !in_range);
  assign do_read  = in_issue && (op_q == OP_READ)  && !acc_err;
  assign do_write = in_issue && (op_q == OP_WRITE) && !acc_err;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_valm_d = rsp_valm_q;
    rsp_err_d  = rsp_err_q;
    acc_cnt_d  = acc_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          data_d  = req_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rsp_valm_d = do_read ? valM : '0;
        rsp_err_d  = acc_err;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          if (!rsp_err_q && (acc_cnt_q != 16'hFFFF)) begin
            acc_cnt_d = acc_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_valm_q <= '0;
      rsp_err_q  <= 1'b0;
      acc_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_valm_q <= rsp_valm_d;
      rsp_err_q  <= rsp_err_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

  // Memory-side outputs decode straight from state so reset removes them at once.
  assign req_ready = (state_q == IDLE);
  assign addr      = in_issue ? addr_q : '0;
  assign data      = in_issue ? data_q : '0;
  assign read      = do_read;
  assign write     = do_write;
  assign rsp_valid = (state_q == RESP);
  assign rsp_valM  = rsp_valm_q;
  assign rsp_err   = rsp_err_q;
  assign acc_cnt   = acc_cnt_q;

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data and address width.
REQ-002 SHALL have parameter ADDR_LO, default 1, lowest valid word address.
REQ-003 SHALL have parameter ADDR_HI, default 20, highest valid word address.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port res  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  access request offered.
REQ-007 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-008 SHALL have port req_op  input  2  01 read, 10 write, 00/11 illegal.
REQ-009 SHALL have port req_addr  input  WIDTH  word address.
REQ-010 SHALL have port req_data  input  WIDTH  write data.
REQ-011 SHALL have port addr  output  WIDTH  memory address.
REQ-012 SHALL have port data  output  WIDTH  memory write data.
REQ-013 SHALL have port read  output  1  memory read strobe.
REQ-014 SHALL have port write  output  1  memory write strobe.
REQ-015 SHALL have port valM  input  WIDTH  combinational read data from memory.
REQ-016 SHALL have port rsp_valid  output  1  response available.
REQ-017 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-018 SHALL have port rsp_valM  output  WIDTH  read data (0 for writes and errors).
REQ-019 SHALL have port rsp_err  output  1  illegal op or out-of-range address.
REQ-020 SHALL have port acc_cnt  output  16  count of completed error-free accesses.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-022 SHALL drive req_ready=1 only in IDLE.
REQ-023 SHALL, in IDLE with req_valid=1, register op/addr/data and enter ISSUE next edge.
REQ-024 SHALL, in ISSUE, drive addr/data from registered values and assert exactly one of read/write per registered op, for exactly one cycle.
REQ-025 SHALL, on a read, capture valM into rsp_valM at the edge ending ISSUE.
REQ-026 SHALL enter RESP from ISSUE unconditionally; rsp_valid=1 throughout RESP.
REQ-027 SHALL hold rsp_valM/rsp_err stable in RESP until rsp_ready=1, then return to IDLE next edge.
REQ-028 SHALL NOT accept a new request in the cycle RESP completes (minimum 3 cycles per access).
REQ-029 SHALL, for illegal op, suppress read/write in ISSUE and report rsp_err=1, rsp_valM=0.
REQ-030 SHALL drive addr, data, read, write to 0 outside ISSUE.
REQ-031 SHALL increment acc_cnt on RESP exit with rsp_err=0, saturating at 16'hFFFF.
REQ-032 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-033 SHALL on res=0 immediately enter IDLE and zero rsp_valid, rsp_valM, rsp_err, read, write, addr, data, acc_cnt; req_ready=1 after release.
REQ-034 SHALL, on reset during ISSUE, drop the access with no write strobe after res falls.

Configuration
REQ-035 SHALL, with MEM_BOUNDS_CHECK_EN defined, treat addresses outside ADDR_LO..ADDR_HI as errors: suppress read/write in ISSUE, rsp_err=1, rsp_valM=0.
REQ-036 SHALL, without MEM_BOUNDS_CHECK_EN, issue all legal-op accesses regardless of address; rsp_err set only by illegal op.

Verification
REQ-037 Write op=10 addr=5 data=0xDEAD, rsp_ready=1 -> write=1 one cycle with addr=5, rsp_valid next cycle, rsp_err=0, acc_cnt=1.
REQ-038 Read op=01 addr=5 after REQ-037 write, valM model=0xDEAD -> rsp_valM=0xDEAD two cycles after accept.
REQ-039 Read with rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_valM stable, req_ready=0, no extra read strobe.
REQ-040 Op=11 addr=3 -> no read/write, rsp_err=1, acc_cnt unchanged; with MEM_BOUNDS_CHECK_EN, addr=21 or 0 -> rsp_err=1, no strobe; without it, addr=21 -> read strobe, rsp_err=0.
REQ-041 Assert res=0 mid-ISSUE of a write -> write falls immediately, all outputs 0, acc_cnt=0, IDLE after release.
